grf: RTL

General register file for the single-issue MIPS datapath, sitting directly downstream of the write-address select stage: it consumes the selected 5-bit write address, write data and write enable, and serves two combinational read ports to decode. Every committed architectural write is also pushed into a small commit-trace FIFO with a valid/ready handshake, so the bench or a debug unit can drain `(pc, reg, data)` records without stalling the pipeline.

---
 rtl/grf_pkg.sv | 18 +
 rtl/grf_trace_fifo.sv | 84 ++++++++
 rtl/grf.sv | 94 +++++++++
 3 files changed

// File: rtl/grf_pkg.sv
// grf_pkg: shared constants and the commit-trace record type for the
// general register file and its trace FIFO.
package grf_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

    // One committed architectural write: {pc, register index, data}.
    typedef struct packed {
        logic [31:0]       pc;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } grf_trace_t;

endpackage : grf_pkg

// File: rtl/grf_trace_fifo.sv
// grf_trace_fifo: commit-trace FIFO with a valid/ready drain side.
// A push into a full FIFO with no simultaneous pop is dropped and sets a
// sticky overflow flag. The head is driven straight from storage, so a
// record pushed into an empty FIFO appears one cycle later (no fall-through).
module grf_trace_fifo
    import grf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  grf_trace_t rec_i,
    input  logic       ready_i,
    output logic       valid_o,
    output grf_trace_t head_o,
    output logic       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    grf_trace_t    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic full;
    logic pop;
    logic push_ok;

    // Handshake qualification and next-state for pointers, count and overflow.
    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        pop      = (cnt_q != '0) && ready_i;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok  = push_i && (!full || pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
        ovf_d = ovf_q | (push_i && full && !pop);
    end

    // Pointer, count and sticky overflow registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Record storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= rec_i;
        end
    end

    // Head outputs straight from storage at the read pointer.
    always_comb begin
        head_o     = mem_q[rd_ptr_q];
        valid_o    = (cnt_q != '0);
        overflow_o = ovf_q;
    end

endmodule : grf_trace_fifo

// File: rtl/grf.sv
// grf: 32 x 32-bit general register file with two combinational read
// ports and a commit-trace FIFO recording every architectural write.
// Optional build macro GRF_BYPASS_EN: forward same-cycle write data to a
// read port addressing the register being written.
module grf
    import grf_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [REG_AW-1:0] Waddr,
    input  logic [REG_DW-1:0] WD,
    input  logic [31:0]       WPC,
    input  logic [REG_AW-1:0] A1,
    input  logic [REG_AW-1:0] A2,
    output logic [REG_DW-1:0] RD1,
    output logic [REG_DW-1:0] RD2,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [REG_AW-1:0] trace_addr,
    output logic [REG_DW-1:0] trace_data,
    output logic              trace_overflow
);

    logic [REG_DW-1:0] regs_q [32];
    logic              wr_en;
    grf_trace_t        push_rec;
    grf_trace_t        head;

    // A write to $0 is not architectural: it neither updates state nor traces.
    always_comb begin
        wr_en    = WE && (Waddr != REG_ZERO);
        push_rec = '{pc: WPC, addr: Waddr, data: WD};
    end

    // Register array; an asynchronous reset clears all entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[Waddr] <= WD;
        end
    end

    // Read port 1: $0 is hardwired to zero.
    always_comb begin
        RD1 = '0;
        if (A1 != REG_ZERO) begin
`ifdef GRF_BYPASS_EN
            RD1 = (wr_en && (Waddr == A1)) ? WD : regs_q[A1];
`else
            RD1 = regs_q[A1];
`endif
        end
    end

    // Read port 2: $0 is hardwired to zero.
    always_comb begin
        RD2 = '0;
        if (A2 != REG_ZERO) begin
`ifdef GRF_BYPASS_EN
            RD2 = (wr_en && (Waddr == A2)) ? WD : regs_q[A2];
`else
            RD2 = regs_q[A2];
`endif
        end
    end

    grf_trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk_i      (clk),
        .rst_i      (reset),
        .push_i     (wr_en),
        .rec_i      (push_rec),
        .ready_i    (trace_ready),
        .valid_o    (trace_valid),
        .head_o     (head),
        .overflow_o (trace_overflow)
    );

    // Unpack the head record onto the trace ports.
    always_comb begin
        trace_pc   = head.pc;
        trace_addr = head.addr;
        trace_data = head.data;
    end

endmodule : grf
